// File: rtl/acorn_decryption_if.sv
// Handshake and data bundle for the bit-serial ACORN-128 decryption core.
// The master side issues start with a state/ciphertext pair; the slave side reports busy/done and results.
interface acorn_decryption_if #(
  parameter int MSG_BITS = 128
);
  logic                start;
  logic [292:0]        state_in;
  logic [MSG_BITS-1:0] ciphertext_in;
  logic                busy;
  logic                done;
  logic [MSG_BITS-1:0] plaintext_out;
  logic [292:0]        state_out;

  modport master (
    output start, state_in, ciphertext_in,
    input  busy, done, plaintext_out, state_out
  );

  modport slave (
    input  start, state_in, ciphertext_in,
    output busy, done, plaintext_out, state_out
  );
endinterface

// File: rtl/acorn_decryption.sv
// Bit-serial ACORN-128 decryption: one StateUpdate128 step per clock, p = c ^ ks fed back into the state.
// Build option ACORN_DEC_PAD_EN adds the 256 padding steps after the message; without it state_out is the post-message state.
module acorn_decryption #(
  parameter int MSG_BITS = 128
`ifdef ACORN_DEC_PAD_EN
  , parameter int PAD_BITS  = 256,
  parameter int CA_PAD_ON = 128
`endif
) (
  input logic               clk,
  input logic               rst_n,
  acorn_decryption_if.slave bus
);

  localparam int IW = $clog2(MSG_BITS);
`ifdef ACORN_DEC_PAD_EN
  localparam logic [8:0] MSG_END = 9'(MSG_BITS);
  localparam logic [8:0] CA_END  = 9'(MSG_BITS + CA_PAD_ON);
  localparam logic [8:0] LAST    = 9'(MSG_BITS + PAD_BITS - 1);
`else
  localparam logic [8:0] LAST    = 9'(MSG_BITS - 1);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e                fsm_q;
  logic [8:0]          cnt_q;
  logic [292:0]        st_q, st_d;
  logic [MSG_BITS-1:0] ct_q, pt_q;
  logic [292:0]        so_q;
  logic                busy_q, done_q;

  logic [292:0]        s;
  logic [IW-1:0]       idx;
  logic                ks, m, ca, f, is_msg;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // Step datapath: in-place LFSR taps (order matters), keystream, then shift in f ^ m.
  always_comb begin
    s      = st_q;
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66]  ^ s[61];
    s[61]  = s[61]  ^ s[23]  ^ s[0];
    ks     = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
    idx    = cnt_q[IW-1:0];
`ifdef ACORN_DEC_PAD_EN
    is_msg = (cnt_q < MSG_END);
    ca     = is_msg || (cnt_q < CA_END);
    m      = is_msg ? (ct_q[idx] ^ ks) : (cnt_q == MSG_END);
`else
    is_msg = 1'b1;
    ca     = 1'b1;
    m      = ct_q[idx] ^ ks;
`endif
    // cb is zero for every decryption and padding step, so the cb&ks term drops out.
    f      = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]);
    st_d   = {f ^ m, s[292:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      cnt_q  <= '0;
      st_q   <= '0;
      ct_q   <= '0;
      pt_q   <= '0;
      so_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (bus.start) begin
            st_q   <= bus.state_in;
            ct_q   <= bus.ciphertext_in;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            fsm_q  <= RUN;
          end
        end
        RUN: begin
          st_q  <= st_d;
          cnt_q <= cnt_q + 9'd1;
          if (is_msg) pt_q[idx] <= m;
          if (cnt_q == LAST) fsm_q <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          so_q   <= st_q;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.plaintext_out = pt_q;
  assign bus.state_out     = so_q;

endmodule

// File: tb/tb_acorn_decryption.sv
// Scoreboard bench for acorn_decryption: random round-trip vectors against a bit-array ACORN reference model.
module tb_acorn_decryption;
  localparam int MB = 128;
`ifdef ACORN_DEC_PAD_EN
  localparam int NSTEPS = 384;
  localparam int ABORT  = 200;
`else
  localparam int NSTEPS = 128;
  localparam int ABORT  = 60;
`endif
  localparam int LAT   = NSTEPS + 1;
  localparam int CA_ON = 128;

  typedef struct {
    logic [MB-1:0] p;
    logic [292:0]  s;
    int            k;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   done_cyc[$];
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acorn_decryption_if #(.MSG_BITS(MB)) bus();
  acorn_decryption #(.MSG_BITS(MB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic bit maj(input bit x, input bit y, input bit z);
    return (int'(x) + int'(y) + int'(z)) >= 2;
  endfunction

  function automatic bit ch(input bit x, input bit y, input bit z);
    return x ? y : z;
  endfunction

  // dec=1: din is ciphertext, dout plaintext. dec=0: din is plaintext, dout ciphertext.
  function automatic void acorn_ref(input logic [292:0] s0, input logic [MB-1:0] din, input bit dec,
                                    output logic [MB-1:0] dout, output logic [292:0] sf);
    bit S[293];
    int tp[6][3];
    bit ks, m, ca, f;
    tp = '{'{289,235,230}, '{230,196,193}, '{193,160,154}, '{154,111,107}, '{107,66,61}, '{61,23,0}};
    dout = '0;
    for (int i = 0; i < 293; i++) S[i] = s0[i];
    for (int n = 0; n < NSTEPS; n++) begin
      for (int t = 0; t < 6; t++) S[tp[t][0]] = S[tp[t][0]] ^ S[tp[t][1]] ^ S[tp[t][2]];
      ks = S[12] ^ S[154] ^ maj(S[235], S[61], S[193]) ^ ch(S[230], S[111], S[66]);
      if (n < MB) begin
        ca = 1'b1;
        if (dec) begin m = din[n] ^ ks; dout[n] = m; end
        else begin m = din[n]; dout[n] = din[n] ^ ks; end
      end else begin
        m  = (n == MB);
        ca = ((n - MB) < CA_ON);
      end
      f = S[0] ^ !S[107] ^ maj(S[244], S[23], S[160]) ^ (ca & S[196]);
      for (int i = 0; i < 292; i++) S[i] = S[i+1];
      S[292] = f ^ m;
    end
    for (int i = 0; i < 293; i++) sf[i] = S[i];
  endfunction

  function automatic logic [292:0] rnd_state();
    logic [292:0] r;
    for (int i = 0; i < 293; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [MB-1:0] rnd_msg();
    logic [MB-1:0] r;
    for (int i = 0; i < MB / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string nm, input logic [292:0] act, input logic [292:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected no pulse", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("plaintext", 293'(bus.plaintext_out), 293'(mon_e.p));
        chk("state_out", bus.state_out, mon_e.s);
        chk("latency", 293'(cyc - mon_e.k), 293'(LAT));
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic [292:0] s, input logic [MB-1:0] c,
                       input logic [MB-1:0] ep, input logic [292:0] es, output int k);
    @(negedge clk);
    bus.state_in      = s;
    bus.ciphertext_in = c;
    bus.start         = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    sb.push_back('{p: ep, s: es, k: k});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic make_vec(output logic [292:0] s, output logic [MB-1:0] c,
                          output logic [MB-1:0] p, output logic [292:0] sf);
    s = rnd_state();
    p = rnd_msg();
    acorn_ref(s, p, 1'b0, c, sf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [292:0] s, sf, s2, sf2;
    logic [MB-1:0] c, p, c2, p2;
    int k, k2, d0;

    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.state_in      = '0;
    bus.ciphertext_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 293'(bus.busy), 293'(0));
    chk("rst_done", 293'(bus.done), 293'(0));
    chk("rst_plaintext", 293'(bus.plaintext_out), 293'(0));
    chk("rst_state_out", bus.state_out, 293'(0));
    rst_n = 1'b1;

    // All-zero state and ciphertext.
    acorn_ref('0, '0, 1'b1, p, sf);
    issue('0, '0, p, sf, k);
    @(posedge clk);
    #1;
    chk("zero_busy", 293'(bus.busy), 293'(1));
    chk("zero_pt0", 293'(bus.plaintext_out[0]), 293'(p[0]));
    drain(LAT + 20);

    // Random round trips: encrypt P with the model, decrypt C in the DUT.
    for (int i = 0; i < 3; i++) begin
      make_vec(s, c, p, sf);
      issue(s, c, p, sf, k);
      drain(LAT + 20);
    end

    // A second start mid-run with different inputs must be ignored.
    make_vec(s, c, p, sf);
    d0 = done_cnt;
    issue(s, c, p, sf, k);
    wait_cyc(k + 50);
    @(negedge clk);
    bus.state_in      = rnd_state();
    bus.ciphertext_in = rnd_msg();
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain(LAT + 20);
    repeat (5) @(posedge clk);
    #1;
    chk("ignored_start_done_count", 293'(done_cnt - d0), 293'(1));

    // Asynchronous abort mid-run, then a clean run.
    make_vec(s, c, p, sf);
    issue(s, c, p, sf, k);
    wait_cyc(k + ABORT);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 293'(bus.busy), 293'(0));
    chk("abort_done", 293'(bus.done), 293'(0));
    chk("abort_plaintext", 293'(bus.plaintext_out), 293'(0));
    chk("abort_state_out", bus.state_out, 293'(0));
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 10) @(posedge clk);
    #1;
    chk("abort_no_done", 293'(done_cnt - d0), 293'(0));
    make_vec(s, c, p, sf);
    issue(s, c, p, sf, k);
    drain(LAT + 20);

    // Back-to-back: start held from the DONE cycle is taken on the first IDLE edge.
    make_vec(s, c, p, sf);
    make_vec(s2, c2, p2, sf2);
    issue(s, c, p, sf, k);
    wait_cyc(k + NSTEPS);
    @(negedge clk);
    bus.state_in      = s2;
    bus.ciphertext_in = c2;
    bus.start         = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    k2 = cyc;
    sb.push_back('{p: p2, s: sf2, k: k2});
    @(negedge clk);
    bus.start = 1'b0;
    drain(2 * LAT + 20);
    if (done_cyc.size() >= 2)
      chk("b2b_spacing", 293'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 293'(LAT + 1));
    else
      chk("b2b_pulses", 293'(done_cyc.size()), 293'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
